// File: rtl/sdram_arbiter_if.sv
// Request/acknowledge bundle between the PPU, CPU and loader requesters, the arbiter,
// and the single SDRAM manager port. Arbiter side is 'slave', requester/manager side is 'master'.
interface sdram_arbiter_if;
    logic        ppu_req;
    logic [24:0] ppu_addr;
    logic        ppu_ack;
    logic [7:0]  ppu_rdata;

    logic        cpu_req;
    logic        cpu_we;
    logic [24:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;

    logic        ldr_req;
    logic        ldr_lh;
    logic [24:0] ldr_addr;
    logic [7:0]  ldr_data;
    logic        ldr_ack;

    logic        mem_req;
    logic        mem_we;
    logic [24:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;

    logic [1:0]  grant;

    modport slave (
        input  ppu_req, ppu_addr,
        output ppu_ack, ppu_rdata,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  ldr_req, ldr_lh, ldr_addr, ldr_data,
        output ldr_ack,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata,
        output grant
    );

    modport master (
        output ppu_req, ppu_addr,
        input  ppu_ack, ppu_rdata,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output ldr_req, ldr_lh, ldr_addr, ldr_data,
        input  ldr_ack,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata,
        input  grant
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Serialises PPU/CPU/loader byte accesses onto one SDRAM manager port, PPU first with a starvation escape.
// Minimum 3 cycles per access (sample, issue until mem_ack, ack); requesters wait by holding req.
module sdram_arbiter #(
    parameter logic [24:0] CHR_BASE     = 25'h100000,
    parameter int          STARVE_LIMIT = 8
) (
    input  logic            sysclk,
    input  logic            reset,
    sdram_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_ACK   = 2'd2
    } state_t;

    localparam logic [1:0] G_NONE = 2'd0;
    localparam logic [1:0] G_PPU  = 2'd1;
    localparam logic [1:0] G_CPU  = 2'd2;
    localparam logic [1:0] G_LDR  = 2'd3;
    localparam logic [7:0] LIMIT  = 8'(STARVE_LIMIT);

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [24:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic [7:0]  ppu_rdata_q, ppu_rdata_d;
    logic [7:0]  cpu_rdata_q, cpu_rdata_d;
    logic [7:0]  starve_q, starve_d;

    logic        others_pending;
    logic        starved;
    logic [24:0] ldr_mapped;

    assign others_pending = bus.cpu_req | bus.ldr_req;
    assign starved        = (starve_q == LIMIT) && others_pending;
    // 25-bit add: loader offsets past the top of the address space wrap around
    assign ldr_mapped     = (bus.ldr_lh ? CHR_BASE : 25'd0) + bus.ldr_addr;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ppu_rdata_d = ppu_rdata_q;
        cpu_rdata_d = cpu_rdata_q;
        starve_d    = starve_q;

        case (state_q)
            S_IDLE: begin
                if (!others_pending) begin
                    starve_d = 8'd0;
                end
                if (bus.ppu_req && !starved) begin
                    grant_d     = G_PPU;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.ppu_addr;
                    mem_wdata_d = 8'd0;
                    state_d     = S_ISSUE;
                    if (others_pending && (starve_q != LIMIT)) begin
                        starve_d = starve_q + 8'd1;
                    end
                end else if (bus.cpu_req) begin
                    grant_d     = G_CPU;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.cpu_we;
                    mem_addr_d  = bus.cpu_addr;
                    mem_wdata_d = bus.cpu_wdata;
                    state_d     = S_ISSUE;
                    starve_d    = 8'd0;
                end else if (bus.ldr_req) begin
                    grant_d     = G_LDR;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ldr_mapped;
                    mem_wdata_d = bus.ldr_data;
                    state_d     = S_ISSUE;
                    starve_d    = 8'd0;
                end
            end
            S_ISSUE: begin
                if (bus.mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = S_ACK;
                    if (grant_q == G_PPU) begin
                        ppu_rdata_d = bus.mem_rdata;
                    end
                    if ((grant_q == G_CPU) && !mem_we_q) begin
                        cpu_rdata_d = bus.mem_rdata;
                    end
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
                grant_d = G_NONE;
            end
            default: begin
                state_d   = S_IDLE;
                grant_d   = G_NONE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            grant_q     <= G_NONE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 25'd0;
            mem_wdata_q <= 8'd0;
            ppu_rdata_q <= 8'd0;
            cpu_rdata_q <= 8'd0;
            starve_q    <= 8'd0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ppu_rdata_q <= ppu_rdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            starve_q    <= starve_d;
        end
    end

    assign bus.ppu_ack   = (state_q == S_ACK) && (grant_q == G_PPU);
    assign bus.cpu_ack   = (state_q == S_ACK) && (grant_q == G_CPU);
    assign bus.ldr_ack   = (state_q == S_ACK) && (grant_q == G_LDR);
    assign bus.ppu_rdata = ppu_rdata_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.grant     = grant_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: behavioural SDRAM manager with programmable latency,
// ack/overlap monitor, and one task per scenario.
module tb_sdram_arbiter;

    logic sysclk;
    logic reset;

    sdram_arbiter_if bus ();

    sdram_arbiter #(
        .CHR_BASE     (25'h100000),
        .STARVE_LIMIT (4)
    ) dut (
        .sysclk (sysclk),
        .reset  (reset),
        .bus    (bus)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    int checks;
    int passes;
    int lat;
    logic [7:0] rdata_val;
    int n_ppu_ack, n_cpu_ack, n_ldr_ack, n_overlap;

    // SDRAM manager model: acks 'lat' cycles after mem_req first appears
    initial begin
        int cnt;
        cnt = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'd0;
        forever begin
            @(posedge sysclk);
            #1;
            if (bus.mem_ack) begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = 8'd0;
                cnt = 0;
            end else if (bus.mem_req) begin
                if (cnt >= lat) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = rdata_val;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin
        n_ppu_ack = 0; n_cpu_ack = 0; n_ldr_ack = 0; n_overlap = 0;
        forever begin
            @(negedge sysclk);
            if (bus.ppu_ack) n_ppu_ack++;
            if (bus.cpu_ack) n_cpu_ack++;
            if (bus.ldr_ack) n_ldr_ack++;
            if ((bus.ppu_ack || bus.cpu_ack || bus.ldr_ack) && bus.mem_req) n_overlap++;
            if ((int'(bus.ppu_ack) + int'(bus.cpu_ack) + int'(bus.ldr_ack)) > 1) n_overlap++;
        end
    end

    task automatic clear_counts();
        n_ppu_ack = 0; n_cpu_ack = 0; n_ldr_ack = 0; n_overlap = 0;
    endtask

    // Returns at the negedge of the mem_ack cycle; cyc = negedges waited minus one
    task automatic wait_mem_ack(output bit ok, output int cyc);
        ok = 1'b0;
        cyc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge sysclk);
            if (bus.mem_ack) begin
                ok = 1'b1;
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.ppu_req = 0; bus.ppu_addr = 0;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.ldr_req = 0; bus.ldr_lh = 0; bus.ldr_addr = 0; bus.ldr_data = 0;
        lat = 0;
        rdata_val = 8'h00;
        repeat (3) @(negedge sysclk);
        checks++;
        if ({bus.ppu_ack, bus.cpu_ack, bus.ldr_ack, bus.mem_req, bus.mem_we} !== 5'b0)
            $display("FAIL reset_ctrl got %b want 00000",
                     {bus.ppu_ack, bus.cpu_ack, bus.ldr_ack, bus.mem_req, bus.mem_we});
        else passes++;
        checks++;
        if (bus.mem_addr !== 25'd0 || bus.mem_wdata !== 8'd0)
            $display("FAIL reset_mem got %h/%h want 0/0", bus.mem_addr, bus.mem_wdata);
        else passes++;
        checks++;
        if (bus.ppu_rdata !== 8'd0 || bus.cpu_rdata !== 8'd0 || bus.grant !== 2'd0)
            $display("FAIL reset_data got %h/%h/%h want 0/0/0", bus.ppu_rdata, bus.cpu_rdata, bus.grant);
        else passes++;
        reset = 1'b1;
        repeat (2) @(negedge sysclk);
        checks++;
        if (bus.grant !== 2'd0 || bus.mem_req !== 1'b0)
            $display("FAIL idle_after_reset got grant=%h req=%b want 0/0", bus.grant, bus.mem_req);
        else passes++;
    endtask

    task automatic test_loader_write();
        bit ok; int cyc;
        clear_counts();
        lat = 3;
        rdata_val = 8'h77;
        bus.ldr_lh = 1'b0; bus.ldr_addr = 25'h000010; bus.ldr_data = 8'hA5; bus.ldr_req = 1'b1;
        wait_mem_ack(ok, cyc);
        checks++;
        if (!ok || cyc !== 3) $display("FAIL ldr_latency got %0d want 3", cyc);
        else passes++;
        checks++;
        if (bus.mem_addr !== 25'h000010 || bus.mem_we !== 1'b1 || bus.mem_wdata !== 8'hA5)
            $display("FAIL ldr_bus got %h/%b/%h want 0000010/1/a5", bus.mem_addr, bus.mem_we, bus.mem_wdata);
        else passes++;
        checks++;
        if (bus.ldr_ack !== 1'b0) $display("FAIL ldr_ack_early got %b want 0", bus.ldr_ack);
        else passes++;
        @(negedge sysclk);
        checks++;
        if (bus.ldr_ack !== 1'b1 || bus.grant !== 2'd3 || bus.mem_req !== 1'b0)
            $display("FAIL ldr_ack_cycle got ack=%b grant=%h req=%b want 1/3/0", bus.ldr_ack, bus.grant, bus.mem_req);
        else passes++;
        bus.ldr_req = 1'b0;
        @(negedge sysclk);
        checks++;
        if (bus.ldr_ack !== 1'b0 || bus.grant !== 2'd0 || n_ldr_ack !== 1)
            $display("FAIL ldr_ack_width got ack=%b grant=%h pulses=%0d want 0/0/1", bus.ldr_ack, bus.grant, n_ldr_ack);
        else passes++;
        checks++;
        if (bus.ppu_rdata !== 8'd0 || bus.cpu_rdata !== 8'd0)
            $display("FAIL ldr_no_rdata got %h/%h want 0/0", bus.ppu_rdata, bus.cpu_rdata);
        else passes++;
    endtask

    task automatic test_chr_map();
        bit ok; int cyc;
        logic [24:0] offs [2];
        logic [24:0] want [2];
        offs[0] = 25'h00001FF;  want[0] = 25'h01001FF;
        offs[1] = 25'h1FFFFFF;  want[1] = 25'h00FFFFF;
        lat = 0;
        for (int t = 0; t < 2; t++) begin
            bus.ldr_lh = 1'b1; bus.ldr_addr = offs[t]; bus.ldr_data = 8'(t + 1); bus.ldr_req = 1'b1;
            wait_mem_ack(ok, cyc);
            checks++;
            if (!ok || bus.mem_addr !== want[t])
                $display("FAIL chr_map%0d got %h want %h", t, bus.mem_addr, want[t]);
            else passes++;
            @(negedge sysclk);
            bus.ldr_req = 1'b0;
            @(negedge sysclk);
        end
    endtask

    task automatic test_simultaneous();
        bit ok; int cyc;
        logic [1:0] seen [3];
        clear_counts();
        lat = 1;
        rdata_val = 8'h11;
        bus.ppu_addr = 25'h0000100;
        bus.cpu_we = 1'b0; bus.cpu_addr = 25'h0000200;
        bus.ldr_lh = 1'b0; bus.ldr_addr = 25'h0000300; bus.ldr_data = 8'h33;
        bus.ppu_req = 1'b1; bus.cpu_req = 1'b1; bus.ldr_req = 1'b1;
        for (int g = 0; g < 3; g++) begin
            wait_mem_ack(ok, cyc);
            seen[g] = ok ? bus.grant : 2'd0;
            @(negedge sysclk);
            if (bus.ppu_ack) bus.ppu_req = 1'b0;
            if (bus.cpu_ack) bus.cpu_req = 1'b0;
            if (bus.ldr_ack) bus.ldr_req = 1'b0;
        end
        bus.ppu_req = 1'b0; bus.cpu_req = 1'b0; bus.ldr_req = 1'b0;
        repeat (3) @(negedge sysclk);
        checks++;
        if (seen[0] !== 2'd1 || seen[1] !== 2'd2 || seen[2] !== 2'd3)
            $display("FAIL sim_order got %0d,%0d,%0d want 1,2,3", seen[0], seen[1], seen[2]);
        else passes++;
        checks++;
        if (n_ppu_ack !== 1 || n_cpu_ack !== 1 || n_ldr_ack !== 1 || n_overlap !== 0)
            $display("FAIL sim_acks got %0d/%0d/%0d overlap=%0d want 1/1/1 overlap=0",
                     n_ppu_ack, n_cpu_ack, n_ldr_ack, n_overlap);
        else passes++;
    endtask

    task automatic test_starvation();
        bit ok; int cyc;
        logic [1:0] seen [6];
        logic [1:0] want [6];
        want[0] = 2'd1; want[1] = 2'd1; want[2] = 2'd1; want[3] = 2'd1; want[4] = 2'd2; want[5] = 2'd1;
        lat = 0;
        rdata_val = 8'h5A;
        bus.ppu_addr = 25'h0000400;
        bus.cpu_we = 1'b0; bus.cpu_addr = 25'h0000040;
        bus.ppu_req = 1'b1; bus.cpu_req = 1'b1;
        for (int g = 0; g < 6; g++) begin
            wait_mem_ack(ok, cyc);
            seen[g] = ok ? bus.grant : 2'd0;
            @(negedge sysclk);
            if (g == 5) begin
                bus.ppu_req = 1'b0;
                bus.cpu_req = 1'b0;
            end
        end
        repeat (2) @(negedge sysclk);
        for (int g = 0; g < 6; g++) begin
            checks++;
            if (seen[g] !== want[g]) $display("FAIL starve_grant%0d got %0d want %0d", g, seen[g], want[g]);
            else passes++;
        end
        checks++;
        if (bus.ppu_rdata !== 8'h5A || bus.cpu_rdata !== 8'h5A)
            $display("FAIL starve_rdata got %h/%h want 5a/5a", bus.ppu_rdata, bus.cpu_rdata);
        else passes++;
    endtask

    task automatic test_cpu_read();
        bit ok; int cyc;
        lat = 2;
        rdata_val = 8'h3C;
        bus.cpu_we = 1'b0; bus.cpu_addr = 25'h000C000; bus.cpu_req = 1'b1;
        wait_mem_ack(ok, cyc);
        checks++;
        if (!ok || bus.mem_addr !== 25'h000C000 || bus.mem_we !== 1'b0)
            $display("FAIL cpu_rd_bus got %h/%b want 000c000/0", bus.mem_addr, bus.mem_we);
        else passes++;
        @(negedge sysclk);
        checks++;
        if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 8'h3C)
            $display("FAIL cpu_rd_ack got ack=%b data=%h want 1/3c", bus.cpu_ack, bus.cpu_rdata);
        else passes++;
        bus.cpu_req = 1'b0;
        @(negedge sysclk);
        // loader write with a different value on mem_rdata must not disturb held read data
        rdata_val = 8'h77;
        bus.ldr_lh = 1'b0; bus.ldr_addr = 25'h0000050; bus.ldr_data = 8'h42; bus.ldr_req = 1'b1;
        wait_mem_ack(ok, cyc);
        @(negedge sysclk);
        bus.ldr_req = 1'b0;
        @(negedge sysclk);
        checks++;
        if (bus.cpu_rdata !== 8'h3C || bus.ppu_rdata !== 8'h5A)
            $display("FAIL rdata_after_ldr got %h/%h want 3c/5a", bus.cpu_rdata, bus.ppu_rdata);
        else passes++;
        rdata_val = 8'hEE;
        bus.cpu_we = 1'b1; bus.cpu_addr = 25'h0000123; bus.cpu_wdata = 8'h99; bus.cpu_req = 1'b1;
        wait_mem_ack(ok, cyc);
        checks++;
        if (!ok || bus.mem_we !== 1'b1 || bus.mem_wdata !== 8'h99 || bus.mem_addr !== 25'h0000123)
            $display("FAIL cpu_wr_bus got %h/%b/%h want 0000123/1/99", bus.mem_addr, bus.mem_we, bus.mem_wdata);
        else passes++;
        @(negedge sysclk);
        bus.cpu_req = 1'b0;
        @(negedge sysclk);
        checks++;
        if (bus.cpu_rdata !== 8'h3C) $display("FAIL cpu_wr_rdata got %h want 3c", bus.cpu_rdata);
        else passes++;
    endtask

    task automatic test_reset_mid();
        bit ok; int cyc; bit seen_req;
        clear_counts();
        lat = 10;
        bus.ldr_lh = 1'b0; bus.ldr_addr = 25'h0000020; bus.ldr_data = 8'h11; bus.ldr_req = 1'b1;
        seen_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge sysclk);
            if (bus.mem_req) begin
                seen_req = 1'b1;
                break;
            end
        end
        @(negedge sysclk);
        checks++;
        if (!seen_req || bus.grant !== 2'd3 || bus.mem_req !== 1'b1)
            $display("FAIL rst_mid_owner got grant=%h req=%b want 3/1", bus.grant, bus.mem_req);
        else passes++;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.mem_req !== 1'b0 || bus.grant !== 2'd0 || bus.ldr_ack !== 1'b0)
            $display("FAIL rst_mid_abort got req=%b grant=%h ack=%b want 0/0/0", bus.mem_req, bus.grant, bus.ldr_ack);
        else passes++;
        repeat (2) @(negedge sysclk);
        lat = 2;
        reset = 1'b1;
        wait_mem_ack(ok, cyc);
        checks++;
        if (!ok || bus.mem_addr !== 25'h0000020 || bus.mem_wdata !== 8'h11 || n_ldr_ack !== 0)
            $display("FAIL rst_reissue got %h/%h acks=%0d want 0000020/11/0", bus.mem_addr, bus.mem_wdata, n_ldr_ack);
        else passes++;
        @(negedge sysclk);
        bus.ldr_req = 1'b0;
        repeat (3) @(negedge sysclk);
        checks++;
        if (n_ldr_ack !== 1) $display("FAIL rst_ack_once got %0d want 1", n_ldr_ack);
        else passes++;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_loader_write();
        test_chr_map();
        test_simultaneous();
        test_starvation();
        test_cpu_read();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Three-way arbiter that shares the single SDRAM manager port between the PPU fetch path, the CPU bus and the SD-card dump loader. It serialises one byte access at a time and maps loader PRG/CHR writes into their SDRAM regions. Each requester gets a one-cycle acknowledge, and read data is held until that requester's next access. It sits between the requesters and the SDRAM manager.

## Interface
- CHR_BASE, 25'h100000, SDRAM base of the CHR region for loader writes with ldr_lh=1
- STARVE_LIMIT, 8, consecutive PPU grants allowed while CPU/loader pending (1..255)
- sysclk  in  1  system clock
- reset  in  1  reset, asynchronous, active-low
- ppu_req  in  1  PPU read request, level, held until ppu_ack
- ppu_addr  in  25  PPU byte address
- ppu_ack  out  1  one-cycle completion pulse
- ppu_rdata  out  8  read data, registered
- cpu_req  in  1  CPU request, level, held until cpu_ack
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  25  CPU byte address
- cpu_wdata  in  8  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  8  read data, registered
- ldr_req  in  1  loader write request, level, held until ldr_ack
- ldr_lh  in  1  0=PRG region (base 0), 1=CHR region (base CHR_BASE)
- ldr_addr  in  25  loader offset within its region
- ldr_data  in  8  loader write data
- ldr_ack  out  1  one-cycle completion pulse
- mem_req  out  1  SDRAM manager request, held until mem_ack
- mem_we  out  1  write enable
- mem_addr  out  25  SDRAM byte address
- mem_wdata  out  8  write data
- mem_ack  in  1  one-cycle completion pulse; mem_rdata valid in the same cycle
- mem_rdata  in  8  read data
- grant  out  2  current owner: 0 none, 1 PPU, 2 CPU, 3 loader

## Operation
- FSM states: S_IDLE, S_ISSUE, S_ACK.
- S_IDLE: sample the requests and pick a winner. If any request is high, register the owner into grant, register mem_addr/mem_we/mem_wdata from the winner, and go to S_ISSUE. Otherwise stay.
- Priority: PPU > CPU > loader. Exception: if starve_cnt == STARVE_LIMIT and CPU or loader is pending, the highest pending non-PPU requester wins.
- starve_cnt (8 bit):
  - Increments on each PPU grant made while cpu_req or ldr_req is high.
  - Clears on any CPU or loader grant.
  - Clears in S_IDLE when neither cpu_req nor ldr_req is high.
  - Saturates at STARVE_LIMIT.
- S_ISSUE: mem_req=1, and address/data are held stable. On mem_ack, latch mem_rdata into the owner's rdata register (PPU, or CPU with cpu_we=0), then go to S_ACK.
- S_ACK: the owner's ack=1 for exactly this cycle. Next state S_IDLE, and grant clears to 0.
- Per-requester mapping:
  - PPU: we=0, wdata=0.
  - CPU: we=cpu_we, address and data passed through.
  - Loader: we=1, address = (ldr_lh ? CHR_BASE : 0) + ldr_addr, truncated to 25 bits (wraps modulo 2^25).
- Loader writes never modify any rdata register. A CPU write does not modify cpu_rdata.
- Requests are sampled only in S_IDLE. Dropping a request during S_ISSUE is a protocol violation: the transaction still completes and the ack still pulses.
- Reset mid-transaction: the FSM returns to S_IDLE immediately, mem_req drops, and no ack is issued. A requester still holding req after reset is re-arbitrated.

## Timing
- Reset values:
  - All outputs are 0: ppu_ack, cpu_ack, ldr_ack, mem_req, mem_we, mem_addr, mem_wdata, ppu_rdata, cpu_rdata, grant.
  - FSM is in S_IDLE and starve_cnt is 0.
- mem_req, mem_addr, mem_we, mem_wdata and grant are registered. Each ack is decoded from the registered state and owner.
- Edge-by-edge sequence for a request first high in S_IDLE at edge E:
  - Edge E: the request is sampled.
  - Cycle E+1: mem_req is high.
  - mem_ack arrives in cycle E+1+k, where k ≥ 0 is the manager latency.
  - Cycle E+2+k: the owner's ack is high.
  - Cycle E+3+k: the FSM is back in S_IDLE.
- Minimum access is 3 cycles, so peak throughput is one byte per 3 cycles.
- The ack lasts exactly one cycle. The requester deasserts req on the edge that ends the ack cycle, so its stale req is never re-sampled.
- rdata is valid from the ack cycle onward and stable until that requester's next read completes.
- mem_ack outside S_ISSUE is ignored.

## Test plan
- Loader write: ldr_lh=0, ldr_addr=0x000010, ldr_data=0xA5, manager latency 3.
  - mem_addr=0x000010, mem_we=1, mem_wdata=0xA5.
  - ldr_ack high exactly one cycle, the cycle after mem_ack.
- CHR mapping: ldr_lh=1, ldr_addr=0x0001FF, CHR_BASE=0x100000.
  - mem_addr=0x1001FF.
  - Also drive ldr_addr=0x1FFFFFF with ldr_lh=1: mem_addr=0x0FFFFF (wrap).
- Simultaneous: ppu_req, cpu_req (read) and ldr_req all rise in the same cycle.
  - Grant order is 1, 2, 3.
  - Exactly one ack pulse per requester, and no overlap of mem transactions.
- Starvation: STARVE_LIMIT=4, ppu_req re-asserted immediately after every ack, cpu_req held high.
  - cpu granted after exactly 4 PPU grants.
  - starve_cnt is then 0, and the PPU regains priority.
- CPU read: cpu_we=0, cpu_addr=0x0C000, mem_rdata=0x3C at mem_ack.
  - cpu_rdata=0x3C in the ack cycle.
  - cpu_rdata stays 0x3C through a following loader write.
- Reset: assert reset while in S_ISSUE with the loader owning the port.
  - mem_req and grant go to 0 immediately, and no ldr_ack is issued.
  - After release, with ldr_req still high, the write is reissued and acked once.
